// File: rtl/timer_host_sequencer_pkg.sv
// Shared definitions for the interval-timer host sequencer: slave register map,
// control bit positions and the sequencer state encoding.
package timer_host_sequencer_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_START  = 2;
  localparam int CTRL_STOP   = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTRL,
    ST_WAIT_IRQ,
    ST_CLR,
    ST_SNAP,
    ST_RD_L,
    ST_RD_H,
    ST_CAP_H,
    ST_REPORT,
    ST_HALT
  } state_e;

  function automatic logic [15:0] ctrl_start_word(input logic continuous);
    logic [15:0] w;
    w              = '0;
    w[CTRL_IRQ_EN] = 1'b1;
    w[CTRL_CONT]   = continuous;
    w[CTRL_START]  = 1'b1;
    return w;
  endfunction

  function automatic logic [15:0] ctrl_stop_word();
    logic [15:0] w;
    w            = '0;
    w[CTRL_STOP] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/timer_host_sequencer.sv
// Programs an Avalon-MM interval timer, services its interrupt, reads back the
// counter snapshot and reports each timeout; all bus outputs are registered.
module timer_host_sequencer
  import timer_host_sequencer_pkg::*;
#(
  parameter int EVT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_period,
  input  logic                 cmd_continuous,
  input  logic                 cmd_stop,
  output logic [2:0]           av_address,
  output logic                 av_chipselect,
  output logic                 av_write_n,
  output logic [15:0]          av_writedata,
  input  logic [15:0]          av_readdata,
  input  logic                 irq,
  output logic                 evt_valid,
  output logic [31:0]          evt_snapshot,
  output logic [EVT_CNT_W-1:0] evt_count,
  output logic                 busy
);

  state_e                 state_q, state_d;
  logic [31:0]            period_q, period_d;
  logic                   cont_q, cont_d;
  logic [15:0]            snap_lo_q, snap_lo_d;
  logic [31:0]            evt_snapshot_q, evt_snapshot_d;
  logic [EVT_CNT_W-1:0]   evt_count_q, evt_count_d;
  logic                   evt_valid_q, evt_valid_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   av_cs_q, av_cs_d;
  logic                   av_write_n_q, av_write_n_d;
  logic [2:0]             av_address_q, av_address_d;
  logic [15:0]            av_writedata_q, av_writedata_d;

  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    cont_d         = cont_q;
    snap_lo_d      = snap_lo_q;
    evt_snapshot_d = evt_snapshot_q;
    evt_count_d    = evt_count_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          period_d    = (cmd_period == 32'd0) ? 32'd1 : cmd_period;
          cont_d      = cmd_continuous;
          evt_count_d = '0;
          state_d     = ST_WR_PL;
        end
      end
      ST_WR_PL:   state_d = ST_WR_PH;
      ST_WR_PH:   state_d = ST_WR_CTRL;
      ST_WR_CTRL: state_d = ST_WAIT_IRQ;
      ST_WAIT_IRQ: begin
        // A stop request wins over a coincident interrupt.
        if (cmd_stop)  state_d = ST_HALT;
        else if (irq)  state_d = ST_CLR;
      end
      ST_CLR:  state_d = ST_SNAP;
      ST_SNAP: state_d = ST_RD_L;
      ST_RD_L: state_d = ST_RD_H;
      ST_RD_H: begin
        snap_lo_d = av_readdata;
        state_d   = ST_CAP_H;
      end
      ST_CAP_H: begin
        evt_snapshot_d = {av_readdata, snap_lo_q};
        evt_count_d    = evt_count_q + EVT_CNT_W'(1);
        state_d        = ST_REPORT;
      end
      ST_REPORT: state_d = cont_q ? ST_WAIT_IRQ : ST_IDLE;
      ST_HALT:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with state_q.
    av_cs_d        = 1'b0;
    av_write_n_d   = 1'b1;
    av_address_d   = ADDR_STATUS;
    av_writedata_d = '0;
    case (state_d)
      ST_WR_PL:   begin av_cs_d = 1'b1; av_write_n_d = 1'b0; av_address_d = ADDR_PERIOD_L; av_writedata_d = period_d[15:0];  end
      ST_WR_PH:   begin av_cs_d = 1'b1; av_write_n_d = 1'b0; av_address_d = ADDR_PERIOD_H; av_writedata_d = period_d[31:16]; end
      ST_WR_CTRL: begin av_cs_d = 1'b1; av_write_n_d = 1'b0; av_address_d = ADDR_CONTROL;  av_writedata_d = ctrl_start_word(cont_d); end
      ST_CLR:     begin av_cs_d = 1'b1; av_write_n_d = 1'b0; av_address_d = ADDR_STATUS; end
      ST_SNAP:    begin av_cs_d = 1'b1; av_write_n_d = 1'b0; av_address_d = ADDR_SNAP_L; end
      ST_RD_L:    begin av_cs_d = 1'b1; av_address_d = ADDR_SNAP_L; end
      ST_RD_H:    begin av_cs_d = 1'b1; av_address_d = ADDR_SNAP_H; end
      ST_HALT:    begin av_cs_d = 1'b1; av_write_n_d = 1'b0; av_address_d = ADDR_CONTROL;  av_writedata_d = ctrl_stop_word(); end
      default:    ;
    endcase
    evt_valid_d = (state_d == ST_REPORT);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      period_q       <= 32'd1;
      cont_q         <= 1'b0;
      snap_lo_q      <= '0;
      evt_snapshot_q <= '0;
      evt_count_q    <= '0;
      evt_valid_q    <= 1'b0;
      cmd_ready_q    <= 1'b1;
      av_cs_q        <= 1'b0;
      av_write_n_q   <= 1'b1;
      av_address_q   <= ADDR_STATUS;
      av_writedata_q <= '0;
    end else begin
      state_q        <= state_d;
      period_q       <= period_d;
      cont_q         <= cont_d;
      snap_lo_q      <= snap_lo_d;
      evt_snapshot_q <= evt_snapshot_d;
      evt_count_q    <= evt_count_d;
      evt_valid_q    <= evt_valid_d;
      cmd_ready_q    <= cmd_ready_d;
      av_cs_q        <= av_cs_d;
      av_write_n_q   <= av_write_n_d;
      av_address_q   <= av_address_d;
      av_writedata_q <= av_writedata_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = ~cmd_ready_q;
  assign av_chipselect = av_cs_q;
  assign av_write_n    = av_write_n_q;
  assign av_address    = av_address_q;
  assign av_writedata  = av_writedata_q;
  assign evt_valid     = evt_valid_q;
  assign evt_snapshot  = evt_snapshot_q;
  assign evt_count     = evt_count_q;

endmodule

// File: tb/tb_timer_host_sequencer.sv
// Directed bench: the sequencer drives a behavioural interval-timer slave whose
// counter steps by tick_step per clock so long periods stay short in simulation.
module tb_timer_host_sequencer;

  localparam int EVT_CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [31:0]          cmd_period;
  logic                 cmd_continuous;
  logic                 cmd_stop;
  logic [2:0]           av_address;
  logic                 av_chipselect;
  logic                 av_write_n;
  logic [15:0]          av_writedata;
  logic [15:0]          av_readdata;
  logic                 irq;
  logic                 evt_valid;
  logic [31:0]          evt_snapshot;
  logic [EVT_CNT_W-1:0] evt_count;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tick_step = 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  timer_host_sequencer #(.EVT_CNT_W(EVT_CNT_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_period    (cmd_period),
    .cmd_continuous(cmd_continuous),
    .cmd_stop      (cmd_stop),
    .av_address    (av_address),
    .av_chipselect (av_chipselect),
    .av_write_n    (av_write_n),
    .av_writedata  (av_writedata),
    .av_readdata   (av_readdata),
    .irq           (irq),
    .evt_valid     (evt_valid),
    .evt_snapshot  (evt_snapshot),
    .evt_count     (evt_count),
    .busy          (busy)
  );

  // Interval-timer slave model: one-shot timeouts reload the period and stop.
  logic [15:0] m_per_l, m_per_h, m_snap_l, m_snap_h;
  logic [31:0] m_cnt;
  logic        m_run, m_cont, m_ien, m_to;
  assign irq = m_to & m_ien;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_per_l <= '0; m_per_h <= '0; m_snap_l <= '0; m_snap_h <= '0;
      m_cnt <= '0; m_run <= 1'b0; m_cont <= 1'b0; m_ien <= 1'b0; m_to <= 1'b0;
      av_readdata <= '0;
    end else begin
      case (av_address)
        3'd0:    av_readdata <= {15'd0, m_to};
        3'd4:    av_readdata <= m_snap_l;
        3'd5:    av_readdata <= m_snap_h;
        default: av_readdata <= '0;
      endcase
      if (m_run) begin
        if (m_cnt <= 32'(tick_step)) begin
          m_to  <= 1'b1;
          m_cnt <= {m_per_h, m_per_l};
          if (!m_cont) m_run <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 32'(tick_step);
        end
      end
      if (av_chipselect && !av_write_n) begin
        case (av_address)
          3'd0: m_to <= 1'b0;
          3'd1: begin
            m_ien  <= av_writedata[0];
            m_cont <= av_writedata[1];
            if (av_writedata[2]) begin
              m_run <= 1'b1;
              m_cnt <= {m_per_h, m_per_l};
              m_to  <= 1'b0;
            end
            if (av_writedata[3]) m_run <= 1'b0;
          end
          3'd2: m_per_l <= av_writedata;
          3'd3: m_per_h <= av_writedata;
          3'd4, 3'd5: {m_snap_h, m_snap_l} <= m_cnt;
          default: ;
        endcase
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic check_wr(input string tag, input logic [2:0] a, input logic [15:0] d);
    check_eq({tag, "_cs"},   av_chipselect, 1);
    check_eq({tag, "_wn"},   av_write_n,    0);
    check_eq({tag, "_addr"}, av_address,    a);
    check_eq({tag, "_data"}, av_writedata,  d);
  endtask

  task automatic check_idle_bus(input string tag);
    check_eq({tag, "_cs"},   av_chipselect, 0);
    check_eq({tag, "_wn"},   av_write_n,    1);
    check_eq({tag, "_addr"}, av_address,    0);
    check_eq({tag, "_data"}, av_writedata,  0);
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called at a sample point with the DUT idle; returns in the WR_CTRL cycle.
  task automatic accept(input logic [31:0] per, input logic cont,
                        input logic [15:0] exp_pl, input logic [15:0] exp_ph,
                        input logic [15:0] exp_ctrl);
    check_eq("cmd_ready_idle", cmd_ready, 1);
    cmd_valid      = 1'b1;
    cmd_period     = per;
    cmd_continuous = cont;
    step_cycle();
    cmd_valid      = 1'b0;
    check_wr("wr_pl", 3'd2, exp_pl);
    check_eq("busy_wr", busy, 1);
    check_eq("count_cleared", evt_count, 0);
    step_cycle();
    check_wr("wr_ph", 3'd3, exp_ph);
    step_cycle();
    check_wr("wr_ctrl", 3'd1, exp_ctrl);
  endtask

  task automatic wait_evt(input int max_cyc, output int evt_at, output int irq_at);
    bit found;
    found  = 1'b0;
    evt_at = -1;
    irq_at = -1;
    for (int i = 0; i < max_cyc && !found; i++) begin
      step_cycle();
      if (irq && irq_at < 0) irq_at = cyc;
      if (evt_valid) begin
        found  = 1'b1;
        evt_at = cyc;
      end
    end
    check_eq("evt_seen", found, 1);
  endtask

  task automatic count_evts(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step_cycle();
      if (evt_valid) pulses++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_idle_bus(tag);
    check_eq({tag, "_ready"}, cmd_ready,    1);
    check_eq({tag, "_busy"},  busy,         0);
    check_eq({tag, "_evt"},   evt_valid,    0);
    check_eq({tag, "_snap"},  evt_snapshot, 0);
    check_eq({tag, "_count"}, evt_count,    0);
  endtask

  initial begin
    int e_at, i_at, prev_e, pulses;
    bit hit;

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_period = '0; cmd_continuous = 1'b0; cmd_stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    step_cycle();

    // One-shot, period 0x10
    tick_step = 1;
    accept(32'h0000_0010, 1'b0, 16'h0010, 16'h0000, 16'h0005);
    wait_evt(200, e_at, i_at);
    check_eq("oneshot_latency", e_at - i_at, 6);
    check_eq("oneshot_count", evt_count, 1);
    check_eq("oneshot_snap", evt_snapshot, 32'h0000_0010);
    check_idle_bus("report_bus");
    step_cycle();
    check_eq("oneshot_evt_pulse", evt_valid, 0);
    check_eq("oneshot_idle", busy, 0);
    count_evts(40, pulses);
    check_eq("oneshot_no_repeat", pulses, 0);
    check_eq("oneshot_count_hold", evt_count, 1);

    // Continuous, period 0x186A0 (timer model steps 100 per clock)
    tick_step = 100;
    accept(32'h0001_86A0, 1'b1, 16'h86A0, 16'h0001, 16'h0007);
    prev_e = 0;
    for (int k = 1; k <= 3; k++) begin
      wait_evt(1500, e_at, i_at);
      check_eq("cont_count", evt_count, k);
      check_eq("cont_snap", evt_snapshot, 32'h0001_85D8);
      if (k > 1) check_eq("cont_spacing", e_at - prev_e, 1000);
      prev_e = e_at;
    end

    // Stop raised while the armed timer waits
    cmd_stop = 1'b1;
    step_cycle();
    check_idle_bus("wait_bus");
    check_eq("wait_busy", busy, 1);
    step_cycle();
    check_wr("halt", 3'd1, 16'h0008);
    check_eq("halt_no_evt", evt_valid, 0);
    cmd_stop = 1'b0;
    step_cycle();
    check_eq("halt_then_idle", cmd_ready, 1);
    count_evts(50, pulses);
    check_eq("halt_no_report", pulses, 0);
    check_eq("halt_count_hold", evt_count, 3);
    check_eq("halt_snap_hold", evt_snapshot, 32'h0001_85D8);

    // Stop and irq in the same WAIT_IRQ cycle
    tick_step = 1;
    accept(32'h0000_0010, 1'b0, 16'h0010, 16'h0000, 16'h0005);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      step_cycle();
      if (irq) hit = 1'b1;
    end
    check_eq("race_irq_seen", hit, 1);
    cmd_stop = 1'b1;
    step_cycle();
    check_wr("race_halt", 3'd1, 16'h0008);
    cmd_stop = 1'b0;
    step_cycle();
    check_eq("race_idle", busy, 0);
    count_evts(30, pulses);
    check_eq("race_no_report", pulses, 0);
    check_eq("race_count", evt_count, 0);

    // Zero period is programmed as 1
    accept(32'h0000_0000, 1'b0, 16'h0001, 16'h0000, 16'h0005);
    wait_evt(200, e_at, i_at);
    check_eq("zero_latency", e_at - i_at, 6);
    check_eq("zero_count", evt_count, 1);
    check_eq("zero_snap", evt_snapshot, 32'h0000_0001);
    step_cycle();

    // Reset asserted during RD_H
    accept(32'h0000_0010, 1'b0, 16'h0010, 16'h0000, 16'h0005);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      step_cycle();
      if (av_chipselect && av_write_n && av_address == 3'd5) hit = 1'b1;
    end
    check_eq("rdh_reached", hit, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step_cycle();
    accept(32'h0000_0010, 1'b0, 16'h0010, 16'h0000, 16'h0005);
    wait_evt(200, e_at, i_at);
    check_eq("post_reset_count", evt_count, 1);
    check_eq("post_reset_snap", evt_snapshot, 32'h0000_0010);
    step_cycle();
    check_eq("post_reset_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_host_sequencer.md
TIMER_HOST_SEQUENCER -- requirements
Module: timer_host_sequencer

Interface
REQ-001 Parameters: one per line, as name, default, meaning.
REQ-002 EVT_CNT_W, 16, width of the timeout event counter.
REQ-003 Ports: one per line, as name, direction, width, meaning. Clock and reset come first.
REQ-004 clk, in, 1, clock; all logic is rising-edge.
REQ-005 reset_n, in, 1, asynchronous active-low reset.
REQ-006 cmd_valid, in, 1, start-request handshake valid.
REQ-007 cmd_ready, out, 1, start-request handshake ready.
REQ-008 cmd_period, in, 32, timeout period in clk cycles, sampled at accept.
REQ-009 cmd_continuous, in, 1, repeat mode, sampled at accept.
REQ-010 cmd_stop, in, 1, level request to halt the armed timer.
REQ-011 av_address, out, 3, Avalon-MM word address to the interval-timer slave.
REQ-012 av_chipselect, out, 1, slave select.
REQ-013 av_write_n, out, 1, active-low write.
REQ-014 av_writedata, out, 16, write data.
REQ-015 av_readdata, in, 16, slave read data, registered in the slave with fixed 1-cycle latency after address; no waitrequest.
REQ-016 irq, in, 1, timer interrupt.
REQ-017 evt_valid, out, 1, one-cycle pulse when a timeout has been serviced.
REQ-018 evt_snapshot, out, 32, counter snapshot captured during servicing.
REQ-019 evt_count, out, EVT_CNT_W, serviced timeouts since the last accept.
REQ-020 busy, out, 1, high whenever state is not IDLE.

Function
REQ-021 Slave register map: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
- Control bits: [0] irq enable, [1] continuous, [2] start, [3] stop.
REQ-022 FSM states: IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, CLR, SNAP, RD_L, RD_H, CAP_H, REPORT, HALT.
REQ-023 cmd_ready = (state == IDLE).
- Accept on cmd_valid && cmd_ready.
- Accept latches period and continuous, clears evt_count, and moves to WR_PL.
REQ-024 cmd_period == 0 is latched as 1.
REQ-025 Each write state issues exactly one cycle with chipselect=1, write_n=0, then advances:
- WR_PL: address 2, data = period[15:0].
- WR_PH: address 3, data = period[31:16].
- WR_CTRL: address 1, data = 16'h0005 (one-shot) or 16'h0007 (continuous).
REQ-026 In IDLE, WAIT_IRQ and REPORT: chipselect=0, write_n=1, address=0, writedata=0.
REQ-027 WAIT_IRQ transitions:
- cmd_stop=1 -> HALT.
- else irq=1 -> CLR.
- else remain in WAIT_IRQ.
REQ-028 HALT writes address 1, data 16'h0008, then goes to IDLE; no evt_valid is produced.
REQ-029 CLR writes address 0, data 0 (clears timeout); SNAP writes address 4, data 0 (latches snapshot).
REQ-030 Snapshot read sequence (chipselect=1, write_n=1 throughout):
- RD_L drives address 4.
- RD_H drives address 5 and captures av_readdata into snapshot[15:0].
- CAP_H drives chipselect=0 and captures av_readdata into snapshot[31:16].
REQ-031 REPORT pulses evt_valid for one cycle with evt_snapshot updated and evt_count incremented (wraps 2^EVT_CNT_W-1 -> 0).
- Next state: WAIT_IRQ if continuous, else IDLE.
REQ-032 Latency:
- Accept to first timer write: 1 cycle.
- irq high in WAIT_IRQ to evt_valid: 6 cycles (CLR, SNAP, RD_L, RD_H, CAP_H, REPORT).
REQ-033 cmd_stop is ignored outside WAIT_IRQ; cmd_valid is ignored while busy.
REQ-034 evt_snapshot and evt_count hold their values between events.

Reset
REQ-035 Asynchronous reset_n low forces:
- state = IDLE; cmd_ready = 1; busy = 0.
- av_chipselect = 0, av_write_n = 1, av_address = 0, av_writedata = 0.
- evt_valid = 0, evt_snapshot = 0, evt_count = 0.
REQ-036 Reset mid-transaction abandons the sequence; no stop write is issued to the slave.

Structure
REQ-037 A shared package holds:
- Register address constants (ADDR_STATUS .. ADDR_SNAP_H).
- Control bit positions.
- The FSM state enum.
REQ-038 Single module; no sub-module, since the FSM and capture registers are small.

Verification
REQ-039 Bench pairs the block with the interval-timer slave model and covers:
- Period 0x0000_0010, one-shot: writes (2,0x0010), (3,0x0000), (1,0x0005) on consecutive cycles; exactly one evt_valid with evt_count=1; then IDLE.
- Period 0x0001_86A0, continuous: evt_valid repeats every period; evt_count reaches 3 after 3 timeouts; control write data = 0x0007.
- cmd_stop raised in WAIT_IRQ: single write (1,0x0008), IDLE next cycle, no evt_valid.
- cmd_stop and irq high in the same cycle: HALT is taken and the event is not reported.
- cmd_period = 0: period_l write data = 0x0001.
- Reset asserted during RD_H: all outputs at reset values immediately; next accept starts cleanly with evt_count=0.
